// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver assembling header/a/b commands; cmd_valid rises 1 cycle after the last stop sample.
// No backpressure on rx: a command completing while one is held and not accepted is dropped (overrun).
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_opcode,
  output logic [7:0] cmd_a,
  output logic [7:0] cmd_b,
  output logic       frame_error,
  output logic       cmd_error,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [4:0] HDR_TAG = 5'b10101;
  localparam logic [1:0] IDX_HDR = 2'd0;
  localparam logic [1:0] IDX_A   = 2'd1;
  localparam logic [1:0] IDX_B   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser and start-edge detection
  // ---------------------------------------------------------------------------
  logic       sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0] fill_q;
  logic       rx_s;
  logic       start_det;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      // Arm only on a high level that came from the line, not from the reset value.
      if (fill_q[1] && sync2_q) armed_q <= 1'b1;
    end
  end

  assign rx_s = sync2_q;

  // ---------------------------------------------------------------------------
  // Bit receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tick;
  logic             cnt_half, cnt_load, shift_en, byte_ok, byte_bad;

  assign tick      = (cnt_q == '0);
  assign start_det = armed_q && prev_q && !rx_s && (state_q == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_det) state_d = S_START;
      S_START: if (tick) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_half = 1'b0;
    cnt_load = 1'b0;
    shift_en = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    unique case (state_q)
      S_IDLE:  cnt_half = start_det;
      S_START: cnt_load = tick;
      S_DATA: begin
        shift_en = tick;
        cnt_load = tick;
      end
      S_STOP: begin
        byte_ok  = tick && rx_s;
        byte_bad = tick && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if (cnt_half)      cnt_q <= CNT_HALF;
      else if (cnt_load) cnt_q <= CNT_FULL;
      else if (!tick)    cnt_q <= cnt_q - 1'b1;

      if (cnt_half) begin
        bit_q <= '0;
      end else if (shift_en) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_q   <= bit_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command assembler, inter-byte timeout and output handshake
  // ---------------------------------------------------------------------------
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            vld_q, vld_d;
  logic [2:0]      opc_q, opc_d;
  logic [7:0]      ca_q, ca_d, cb_q, cb_d;
  logic            fe_q, fe_d, ce_q, ce_d, ov_q, ov_d;
  logic            to_expire;

  // A start edge in the expiry cycle wins over the timeout.
  assign to_expire = (idx_q != IDX_HDR) && (to_cnt_q == TO_LAST) && !start_det && !byte_ok;

  always_comb begin
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    vld_d    = vld_q;
    opc_d    = opc_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    fe_d     = byte_bad;
    ce_d     = 1'b0;
    ov_d     = 1'b0;
    to_cnt_d = to_cnt_q;

    if (vld_q && cmd_ready) vld_d = 1'b0;

    if (byte_bad) begin
      idx_d = IDX_HDR;
    end else if (byte_ok) begin
      unique case (idx_q)
        IDX_HDR: begin
          if (shift_q[7:3] == HDR_TAG) begin
            op_d  = shift_q[2:0];
            idx_d = IDX_A;
          end else begin
            ce_d = 1'b1;
          end
        end
        IDX_A: begin
          a_d   = shift_q;
          idx_d = IDX_B;
        end
        IDX_B: begin
          idx_d = IDX_HDR;
          if (vld_q && !cmd_ready) begin
            ov_d = 1'b1;
          end else begin
            vld_d = 1'b1;
            opc_d = op_q;
            ca_d  = a_q;
            cb_d  = shift_q;
          end
        end
        default: idx_d = IDX_HDR;
      endcase
    end else if (to_expire) begin
      idx_d = IDX_HDR;
      ce_d  = 1'b1;
    end

    if (idx_q == IDX_HDR || start_det || byte_ok) to_cnt_d = '0;
    else if (to_cnt_q != TO_LAST)                 to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q    <= IDX_HDR;
      op_q     <= '0;
      a_q      <= '0;
      to_cnt_q <= '0;
      vld_q    <= 1'b0;
      opc_q    <= '0;
      ca_q     <= '0;
      cb_q     <= '0;
      fe_q     <= 1'b0;
      ce_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      to_cnt_q <= to_cnt_d;
      vld_q    <= vld_d;
      opc_q    <= opc_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      fe_q     <= fe_d;
      ce_q     <= ce_d;
      ov_q     <= ov_d;
    end
  end

  assign cmd_valid   = vld_q;
  assign cmd_opcode  = opc_q;
  assign cmd_a       = ca_q;
  assign cmd_b       = cb_q;
  assign frame_error = fe_q;
  assign cmd_error   = ce_q;
  assign overrun     = ov_q;
  assign busy        = (state_q != S_IDLE) || (idx_q != IDX_HDR);

endmodule
